// File: rtl/mips_alu_unit.sv
// mips_alu_unit -- 32-bit MIPS-I ALU with HI/LO register pair.
//
// Ports:
//   clk         in   1   clock; HI/LO update on rising edge
//   rst         in   1   asynchronous active-high reset; clears HI/LO
//   ALUControl  in   5   operation select
//   alu_src_1   in  32   operand A (rs, or zero-extended shamt)
//   alu_src_2   in  32   operand B (rt, or sign-extended immediate)
//   alu_result  out 32   combinational result
//   branch      out  1   combinational branch condition
//
// Build option: define MIPS_ALU_MULDIV_EN to implement MULT/MULTU/DIV/DIVU,
// MTHI/MTLO, MFHI/MFLO and the HI/LO registers. Without it those codes act
// as reserved and clk/rst are unused.
module mips_alu_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ALUControl,
    input  logic [31:0] alu_src_1,
    input  logic [31:0] alu_src_2,
    output logic [31:0] alu_result,
    output logic        branch
);

    typedef enum logic [4:0] {
        OP_ADDU  = 5'd0,  OP_SUBU  = 5'd1,  OP_AND   = 5'd2,  OP_OR    = 5'd3,
        OP_XOR   = 5'd4,  OP_SLT   = 5'd5,  OP_SLTU  = 5'd6,  OP_SLL   = 5'd7,
        OP_SRL   = 5'd8,  OP_SRA   = 5'd9,  OP_SLLV  = 5'd10, OP_SRLV  = 5'd11,
        OP_SRAV  = 5'd12, OP_LUI   = 5'd13, OP_MULT  = 5'd14, OP_MULTU = 5'd15,
        OP_DIV   = 5'd16, OP_DIVU  = 5'd17, OP_MTHI  = 5'd18, OP_MTLO  = 5'd19,
        OP_MFHI  = 5'd20, OP_MFLO  = 5'd21, OP_BEQ   = 5'd22, OP_BNE   = 5'd23,
        OP_BGTZ  = 5'd24, OP_BLEZ  = 5'd25, OP_BLTZ  = 5'd26, OP_BGEZ  = 5'd27
    } alu_op_t;

    alu_op_t     op;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;

    assign op    = alu_op_t'(ALUControl);
    assign a     = alu_src_1;
    assign b     = alu_src_2;
    assign shamt = a[4:0];

`ifdef MIPS_ALU_MULDIV_EN
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] mul_s;
    logic [63:0] mul_u;
    logic [31:0] divisor;
    logic        div_ovf;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] quo_u;
    logic [31:0] rem_u;

    // Sign/zero-extend to 64 bits so the low 64 product bits are exact.
    assign mul_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign mul_u = {32'd0, a} * {32'd0, b};

    // Divide-by-zero never writes, so a safe divisor only avoids X results.
    assign divisor = (b == '0) ? 32'd1 : b;
    // The single signed quotient that does not fit in 32 bits.
    assign div_ovf = (a == 32'h8000_0000) && (b == '1);
    assign quo_s   = div_ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(divisor));
    assign rem_s   = div_ovf ? '0            : 32'($signed(a) % $signed(divisor));
    assign quo_u   = a / divisor;
    assign rem_u   = a % divisor;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else begin
            case (op)
                OP_MULT:  {hi, lo} <= mul_s;
                OP_MULTU: {hi, lo} <= mul_u;
                OP_DIV: begin
                    if (b != '0) begin
                        lo <= quo_s;
                        hi <= rem_s;
                    end
                end
                OP_DIVU: begin
                    if (b != '0) begin
                        lo <= quo_u;
                        hi <= rem_u;
                    end
                end
                OP_MTHI:  hi <= a;
                OP_MTLO:  lo <= a;
                default:  ;
            endcase
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
`endif

    always_comb begin
        alu_result = '0;
        branch     = 1'b0;
        case (op)
            OP_ADDU: alu_result = a + b;
            OP_SUBU: alu_result = a - b;
            OP_AND:  alu_result = a & b;
            OP_OR:   alu_result = a | b;
            OP_XOR:  alu_result = a ^ b;
            OP_SLT:  alu_result = {31'd0, $signed(a) < $signed(b)};
            OP_SLTU: alu_result = {31'd0, a < b};
            OP_SLL, OP_SLLV: alu_result = b << shamt;
            OP_SRL, OP_SRLV: alu_result = b >> shamt;
            OP_SRA, OP_SRAV: alu_result = $signed(b) >>> shamt;
            OP_LUI:  alu_result = {b[15:0], 16'h0000};
`ifdef MIPS_ALU_MULDIV_EN
            OP_MFHI: alu_result = hi;
            OP_MFLO: alu_result = lo;
`endif
            OP_BEQ:  branch = (a == b);
            OP_BNE:  branch = (a != b);
            OP_BGTZ: branch = !a[31] && (a != '0);
            OP_BLEZ: branch = a[31] || (a == '0);
            OP_BLTZ: branch = a[31];
            OP_BGEZ: branch = !a[31];
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_alu_unit.sv
// Self-checking bench for mips_alu_unit: directed corner cases plus random
// vectors checked against an arithmetic reference model. HI/LO checks are
// only compiled when MIPS_ALU_MULDIV_EN is defined.
module tb_mips_alu_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ALUControl;
    logic [31:0] alu_src_1;
    logic [31:0] alu_src_2;
    logic [31:0] alu_result;
    logic        branch;

    int vectors = 0;
    int errors  = 0;

    // Reference HI/LO state.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mips_alu_unit dut (
        .clk        (clk),
        .rst        (rst),
        .ALUControl (ALUControl),
        .alu_src_1  (alu_src_1),
        .alu_src_2  (alu_src_2),
        .alu_result (alu_result),
        .branch     (branch)
    );

    always #5 clk = ~clk;

    // Reference: computed from the operation definitions with 64-bit
    // integer arithmetic rather than bit operators where practical.
    function automatic void ref_model(input int unsigned op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] r,
                                      output logic br);
        longint sa, sb, p2;
        int unsigned sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = a % 32;
        p2 = longint'(1) << sh;
        r  = '0;
        br = 1'b0;
        case (op)
            0:  r = 32'(longint'(a) + longint'(b));
            1:  r = 32'(longint'(a) - longint'(b));
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = (sa < sb) ? 32'd1 : 32'd0;
            6:  r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            7, 10: r = 32'(longint'(b) * p2);
            8, 11: r = 32'(longint'(b) / p2);
            9, 12: r = (sb >= 0) ? 32'(sb / p2) : 32'((sb - (p2 - 1)) / p2);
            13: r = 32'(longint'(b % 65536) * 65536);
`ifdef MIPS_ALU_MULDIV_EN
            20: r = m_hi;
            21: r = m_lo;
`endif
            22: br = (a == b);
            23: br = (a != b);
            24: br = (sa > 0);
            25: br = (sa <= 0);
            26: br = (sa < 0);
            27: br = (sa >= 0);
            default: ;
        endcase
    endfunction

    // Reference for the HI/LO effect of one clock edge.
    task automatic model_edge(input int unsigned op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        longint unsigned pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            14: begin p  = sa * sb; m_hi = p[63:32];  m_lo = p[31:0];  end
            15: begin pu = longint'(a) * longint'(b); m_hi = pu[63:32]; m_lo = pu[31:0]; end
            16: if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            17: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            18: m_hi = a;
            19: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic drive(input int unsigned op, input logic [31:0] a, input logic [31:0] b);
        ALUControl = 5'(op);
        alu_src_1  = a;
        alu_src_2  = b;
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] er;
        logic        eb;
        rst = 1'b1;
        drive(0, '0, '0);
        @(posedge clk); #1;
        for (int unsigned op = 20; op <= 21; op++) begin
            drive(op, 32'h1234_5678, 32'h9ABC_DEF0);
            ref_model(op, alu_src_1, alu_src_2, er, eb);
            vectors++;
            if (alu_result !== 32'd0 || branch !== 1'b0 || er !== 32'd0) begin
                errors++;
                $display("FAIL reset_read op=%0d: got %h/%b, want 00000000/0", op, alu_result, branch);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [31:0] exp_r [10];
        int unsigned ops   [10];
        logic [31:0] as    [10];
        logic [31:0] bs    [10];
        ops = '{0, 1, 5, 6, 9, 8, 13, 7, 2, 4};
        as  = '{32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h24, 32'h24,
                32'd0, 32'd31, 32'hF0F0_F0F0, 32'hFFFF_0000};
        bs  = '{32'd1, 32'd1, 32'd1, 32'd1, 32'h8000_0000, 32'h8000_0000,
                32'h1234, 32'd3, 32'h0FF0_0FF0, 32'h00FF_FF00};
        exp_r = '{32'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hF800_0000, 32'h0800_0000,
                  32'h1234_0000, 32'h8000_0000, 32'h00F0_00F0, 32'hFF00_FF00};
        for (int i = 0; i < 10; i++) begin
            drive(ops[i], as[i], bs[i]);
            vectors++;
            if (alu_result !== exp_r[i] || branch !== 1'b0) begin
                errors++;
                $display("FAIL directed_%0d op=%0d: got %h/%b, want %h/0", i, ops[i], alu_result, branch, exp_r[i]);
            end
        end
    endtask

    task automatic test_branch;
        int unsigned ops [8];
        logic [31:0] as  [8];
        logic        eb  [8];
        ops = '{24, 25, 26, 27, 22, 23, 30, 24};
        as  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd5, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000};
        eb  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            drive(ops[i], as[i], (ops[i] == 30) ? 32'hFFFF_FFFF : 32'd5);
            vectors++;
            if (branch !== eb[i] || alu_result !== 32'd0) begin
                errors++;
                $display("FAIL branch_%0d op=%0d: got %h/%b, want 00000000/%b", i, ops[i], alu_result, branch, eb[i]);
            end
        end
    endtask

    task automatic test_random_comb;
        logic [31:0] a, b, er;
        logic        eb;
        int unsigned op;
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(31);
`ifdef MIPS_ALU_MULDIV_EN
            if (op >= 14 && op <= 19) op = op + 8;   // keep HI/LO untouched here
`endif
            a = $urandom();
            b = $urandom();
            case ($urandom_range(7))
                0: a = b;
                1: a = '0;
                2: a = 32'h8000_0000;
                3: b = '1;
                default: ;
            endcase
            drive(op, a, b);
            ref_model(op, a, b, er, eb);
            vectors++;
            if (alu_result !== er || branch !== eb) begin
                errors++;
                $display("FAIL random op=%0d a=%h b=%h: got %h/%b, want %h/%b", op, a, b, alu_result, branch, er, eb);
            end
        end
    endtask

`ifdef MIPS_ALU_MULDIV_EN
    // Apply a HI/LO-writing op across one edge, then read both registers.
    task automatic test_back_to_back;
        logic [31:0] a, b;
        int unsigned op;
        int unsigned ops [6];
        logic [31:0] as  [6];
        logic [31:0] bs  [6];
        ops = '{14, 15, 16, 16, 16, 18};
        as  = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'h1234, 32'h8000_0000, 32'hDEAD_BEEF};
        bs  = '{32'd3, 32'd3, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
        for (int i = 0; i < 6 + 150; i++) begin
            if (i < 6) begin
                op = ops[i]; a = as[i]; b = bs[i];
            end else begin
                op = 14 + $urandom_range(5);
                a = $urandom();
                b = ($urandom_range(5) == 0) ? 32'd0 : $urandom();
                if ($urandom_range(7) == 0) b = '1;
            end
            drive(op, a, b);
            @(posedge clk); #1;
            model_edge(op, a, b);
            if ($urandom_range(2) == 0) begin
                // Holding the op for another edge must rewrite identical values.
                @(posedge clk); #1;
                model_edge(op, a, b);
            end
            drive(20, $urandom(), $urandom());
            vectors++;
            if (alu_result !== m_hi) begin
                errors++;
                $display("FAIL mfhi op=%0d a=%h b=%h: got %h, want %h", op, a, b, alu_result, m_hi);
            end
            drive(21, $urandom(), $urandom());
            vectors++;
            if (alu_result !== m_lo) begin
                errors++;
                $display("FAIL mflo op=%0d a=%h b=%h: got %h, want %h", op, a, b, alu_result, m_lo);
            end
        end
    endtask

    task automatic test_async_reset;
        drive(18, 32'hDEAD_BEEF, 32'd0);
        @(posedge clk); #1;
        model_edge(18, 32'hDEAD_BEEF, 32'd0);
        drive(19, 32'hCAFE_F00D, 32'd0);
        @(posedge clk); #2;
        model_edge(19, 32'hCAFE_F00D, 32'd0);
        drive(20, '0, '0);
        vectors++;
        if (alu_result !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mthi_before_reset: got %h, want deadbeef", alu_result);
        end
        rst = 1'b1;
        #1;
        m_hi = '0;
        m_lo = '0;
        vectors++;
        if (alu_result !== 32'd0) begin
            errors++;
            $display("FAIL async_reset_hi: got %h, want 00000000", alu_result);
        end
        // Write attempted across an edge while reset is held must be dropped.
        drive(19, 32'h5555_AAAA, 32'd0);
        @(posedge clk); #1;
        drive(21, '0, '0);
        vectors++;
        if (alu_result !== 32'd0) begin
            errors++;
            $display("FAIL reset_blocks_write: got %h, want 00000000", alu_result);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask
`endif

    initial begin
        rst        = 1'b1;
        ALUControl = '0;
        alu_src_1  = '0;
        alu_src_2  = '0;
        test_reset();
        test_directed();
        test_branch();
        test_random_comb();
`ifdef MIPS_ALU_MULDIV_EN
        test_back_to_back();
        test_async_reset();
        test_random_comb();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1);
    end

endmodule
